// File: rtl/tx_pkg.sv
// Shared types and helpers for the UART transmit engine.
// No latency: declarations and a pure function only.
// No flow control of its own.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } tx_state_e;

  localparam int FRAME_BITS = 11;
  localparam int BITCNT_W   = 4;

  // Parity over the enabled data bits; ohel=1 selects odd sense.
  function automatic logic tx_parity(input logic [7:0] data,
                                     input logic       eight,
                                     input logic       ohel);
    logic [7:0] masked;
    masked = eight ? data : {1'b0, data[6:0]};
    return (^masked) ^ ohel;
  endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-time divisor: counts 0..div-1 while enabled, pulses tick on the last count.
// Tick is combinational from the counter flop; it is meaningful only while en is high.
// No backpressure; clr has priority over en.
module tx_baud_gen
  import tx_pkg::*;
#(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [BAUD_W-1:0] div,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == (div - BAUD_W'(1)));

  // Next count: clear on load, wrap to zero on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : (cnt_q + BAUD_W'(1));
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_engine.sv
// UART transmit engine: serialises LOAD_DATA as an 11-bit-time frame on TX.
// Start bit appears the cycle after DOIT is sampled; DONE pulses one cycle after the 11th bit time.
// No backpressure: DOIT is ignored outside IDLE. Parity support built only with TX_PARITY_EN defined.
module tx_engine
  import tx_pkg::*;
#(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DOIT,
  input  logic [7:0]        LOAD_DATA,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  input  logic [BAUD_W-1:0] BAUD_VAL,
  output logic              TX,
  output logic              DONE
);

  tx_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BITCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic                 done_q, done_d;

  logic                 baud_clr;
  logic                 baud_en;
  logic                 baud_tick;
  logic                 par_slot;
  logic [FRAME_BITS-1:0] frame_load;

  // Slot following the data bits: parity when enabled, otherwise a stop-level 1.
`ifdef TX_PARITY_EN
  always_comb begin
    par_slot = 1'b1;
    if (PEN) begin
      par_slot = tx_parity(LOAD_DATA, EIGHT, OHEL);
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = &{1'b0, PEN, OHEL};
  assign par_slot = 1'b1;
`endif

  // Frame image, bit 0 goes out first. Capturing the formatted frame here is what
  // freezes EIGHT/PEN/OHEL for the whole frame.
  always_comb begin
    frame_load = '1;
    if (EIGHT) begin
      frame_load = {1'b1, par_slot, LOAD_DATA, 1'b0};
    end else begin
      frame_load = {2'b11, par_slot, LOAD_DATA[6:0], 1'b0};
    end
  end

  tx_baud_gen #(
    .BAUD_W (BAUD_W)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (reset),
    .clr   (baud_clr),
    .en    (baud_en),
    .div   (baud_q),
    .tick  (baud_tick)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;
    baud_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (DOIT) begin
          shift_d   = frame_load;
          bit_cnt_d = '0;
          // A zero divisor would never reach terminal count; run it at one clock per bit.
          baud_d    = (BAUD_VAL == '0) ? BAUD_W'(1) : BAUD_VAL;
          baud_clr  = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        baud_en = 1'b1;
        if (baud_tick) begin
          shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          if (bit_cnt_q == BITCNT_W'(FRAME_BITS - 1)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      FIN: begin
        // Always pass through IDLE so a DOIT still high from this frame is not reused.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register, counters and DONE flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      baud_q    <= BAUD_W'(1);
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      done_q    <= done_d;
    end
  end

  // Shift register idles and drains to all ones, so TX is high outside a frame.
  assign TX   = shift_q[0];
  assign DONE = done_q;

endmodule

// File: tb/tb_tx_engine.sv
module tb_tx_engine;

  logic        clk;
  logic        rst_n;
  logic        doit;
  logic [7:0]  load_data;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [18:0] baud_val;
  logic        tx;
  logic        done;

  int checks = 0;
  int errors = 0;
  int prints = 0;

  tx_engine #(.BAUD_W(19)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .DOIT      (doit),
    .LOAD_DATA (load_data),
    .EIGHT     (eight),
    .PEN       (pen),
    .OHEL      (ohel),
    .BAUD_VAL  (baud_val),
    .TX        (tx),
    .DONE      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

`ifdef TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  // Line-order frame: bit k is the k-th bit time on TX.
  function automatic logic [10:0] frame_model(input logic [7:0] d, input logic e8,
                                              input logic pe, input logic odd);
    logic [10:0] f;
    int n;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    n    = e8 ? 8 : 7;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      f[1 + i] = d[i];
      ones += int'(d[i]);
    end
    if (pe && PAR_BUILT) f[1 + n] = ((ones % 2) == 1) ^ odd;
    return f;
  endfunction

  // Timeline model: phase 0 idle, 1 frame in progress (m_t clocks since start), 2 DONE cycle.
  int          m_phase = 0;
  int          m_t = 0;
  int          m_baud = 1;
  logic [10:0] m_bits = '1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_t     = 0;
    end else begin
      case (m_phase)
        0: if (doit) begin
             m_bits  = frame_model(load_data, eight, pen, ohel);
             m_baud  = (baud_val == 0) ? 1 : int'(baud_val);
             m_t     = 0;
             m_phase = 1;
           end
        1: begin
             m_t++;
             if (m_t == 11 * m_baud) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic exp_tx;
    logic exp_done;
    exp_tx   = (m_phase == 1) ? m_bits[m_t / m_baud] : 1'b1;
    exp_done = (m_phase == 2);
    checks++;
    if (tx !== exp_tx || done !== exp_done) begin
      errors++;
      if (prints < 20) begin
        prints++;
        $display("FAIL model_cycle t=%0t tx=%b done=%b required tx=%b done=%b",
                 $time, tx, done, exp_tx, exp_done);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] d, input logic e8, input logic pe,
                       input logic odd, input int b, input bit hold);
    @(negedge clk);
    #1;
    load_data = d;
    eight     = e8;
    pen       = pe;
    ohel      = odd;
    baud_val  = 19'(b);
    doit      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) doit = 1'b0;
  endtask

  // Called just after the sampling edge; records one sample per bit time and the DONE cycle.
  task automatic capture(input int b, input int chg_at, output logic [10:0] bits,
                         output int done_c, output int done_n, output int bad);
    bits   = '1;
    done_c = -1;
    done_n = 0;
    bad    = 0;
    for (int c = 1; c <= 11 * b + 3; c++) begin
      @(negedge clk);
      if (c == chg_at) begin
        baud_val = 19'd8;
        pen      = 1'b0;
      end
      if (c <= 11 * b) begin
        if (((c - 1) % b) == 0) bits[(c - 1) / b] = tx;
        else if (tx !== bits[(c - 1) / b]) bad++;
      end
      if (done === 1'b1) begin
        done_n++;
        done_c = c;
      end
    end
  endtask

  logic [10:0] bits;
  int          dc, dn, bad;
  logic [10:0] a5_exp;
  logic [0:0]  tx_s [1:200];
  logic [0:0]  dn_s [1:200];

  initial begin
    a5_exp    = PAR_BUILT ? 11'b10101001010 : 11'b11101001010;
    rst_n     = 1'b0;
    doit      = 1'b0;
    load_data = 8'h00;
    eight     = 1'b1;
    pen       = 1'b0;
    ohel      = 1'b0;
    baud_val  = 19'd4;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_done", int'(done), 0);
    #1 rst_n = 1'b1;

    // 8 data bits, even parity, 4 clocks per bit.
    start(8'hA5, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    capture(4, 0, bits, dc, dn, bad);
    chk("a5_bits", int'(bits), int'(a5_exp));
    chk("a5_done_cycle", dc, 45);
    chk("a5_done_count", dn, 1);
    chk("a5_bit_width", bad, 0);

    // 7 data bits, no parity: bit 7 of the byte never reaches the line.
    start(8'hC1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    capture(3, 0, bits, dc, dn, bad);
    chk("c1_bits", int'(bits), int'(11'b11110000010));
    chk("c1_done_cycle", dc, 34);
    chk("c1_bit_width", bad, 0);

    // Parity sense on an all-zero byte.
    start(8'h00, 1'b1, 1'b1, 1'b1, 4, 1'b0);
    capture(4, 0, bits, dc, dn, bad);
    chk("odd_parity_bit9", int'(bits[9]), 1);
    start(8'h00, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    capture(4, 0, bits, dc, dn, bad);
    chk("even_parity_bit9", int'(bits[9]), PAR_BUILT ? 0 : 1);

    // Zero divisor runs at one clock per bit.
    start(8'h55, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    capture(1, 0, bits, dc, dn, bad);
    chk("baud0_bits", int'(bits), int'(11'b11010101010));
    chk("baud0_done_cycle", dc, 12);

    // Back-to-back: DOIT held through DONE with new data written during the DONE cycle.
    start(8'hA5, 1'b1, 1'b1, 1'b0, 4, 1'b1);
    dn = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      tx_s[c] = tx;
      dn_s[c] = done;
      if (done === 1'b1) begin
        dn++;
        if (dn == 1) load_data = 8'h3C;
        if (dn == 2) begin
          @(posedge clk);
          #1 doit = 1'b0;
        end
      end
    end
    begin
      int gap;
      int pulses;
      int second_c;
      int late_low;
      gap = 0;
      for (int c = 45; c <= 60; c++) begin
        if (tx_s[c] !== 1'b1) break;
        gap++;
      end
      pulses   = 0;
      second_c = -1;
      late_low = 0;
      for (int c = 1; c <= 200; c++) begin
        if (dn_s[c] === 1'b1) begin
          pulses++;
          if (pulses == 2) second_c = c;
        end
        if (c > 91 && tx_s[c] !== 1'b1) late_low++;
      end
      chk("b2b_idle_gap", gap, 2);
      chk("b2b_done_pulses", pulses, 2);
      chk("b2b_second_done_cycle", second_c, 91);
      chk("b2b_no_third_frame", late_low, 0);
    end

    // Asynchronous reset in the middle of data bit 4.
    start(8'hA5, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    repeat (21) @(negedge clk);
    chk("rst_pre_tx", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", int'(tx), 1);
    chk("rst_async_done", int'(done), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    dn  = 0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (tx !== 1'b1) bad++;
    end
    chk("rst_after_done", dn, 0);
    chk("rst_after_tx_low", bad, 0);

    // Config change mid-frame only affects the next frame.
    start(8'hA5, 1'b1, 1'b1, 1'b0, 4, 1'b0);
    capture(4, 10, bits, dc, dn, bad);
    chk("cfg_first_bits", int'(bits), int'(a5_exp));
    chk("cfg_first_done_cycle", dc, 45);
    chk("cfg_first_bit_width", bad, 0);
    start(8'h3C, 1'b1, 1'b0, 1'b0, 8, 1'b0);
    capture(8, 0, bits, dc, dn, bad);
    chk("cfg_second_bits", int'(bits), int'(11'b11001111000));
    chk("cfg_second_done_cycle", dc, 89);
    chk("cfg_second_bit_width", bad, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_engine.md
# tx_engine

UART transmit engine. Consumes the byte and start request produced by the transmit load/handshake register stage: LOAD_DATA and DOIT. Serialises the byte onto TX as an 11-bit-time frame at a programmable baud. Returns a one-cycle DONE pulse so the handshake stage can clear DOIT and raise TXRDY.

## Interface
- BAUD_W, 19, width of the baud divisor input.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- DOIT  input  1  transmit request level; stays high until one cycle after DONE.
- LOAD_DATA  input  8  byte to send; stable while DOIT is high.
- EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits (LOAD_DATA[7] ignored).
- PEN  input  1  parity enable.
- OHEL  input  1  parity sense: 1 = odd, 0 = even.
- BAUD_VAL  input  BAUD_W  clocks per bit time.
- TX  output  1  serial line, idle high.
- DONE  output  1  one-cycle frame-complete pulse.

## Operation
- States:
  - IDLE: wait for DOIT.
  - SHIFT: frame on the line.
  - FIN: emit the DONE pulse.
- In IDLE with DOIT=1 at a clock edge:
  - Latch BAUD_VAL, EIGHT, PEN, OHEL.
  - Load the 11-bit shift register, LSB first on the line.
  - Clear the baud and bit counters.
  - Enter SHIFT.
- Frame layout in line order:
  - EIGHT=1, PEN=1: start 0, d0..d7, parity, stop 1.
  - EIGHT=1, PEN=0: 0, d0..d7, 1, 1.
  - EIGHT=0, PEN=1: 0, d0..d6, parity, 1, 1.
  - EIGHT=0, PEN=0: 0, d0..d6, 1, 1, 1.
- Parity is computed over the enabled data bits only.
  - Even: XOR of the data bits.
  - Odd: inverted XOR.
- Baud counter counts 0..BAUD_VAL−1. At terminal count: shift the register right (fill with 1), increment the bit counter, reset the baud counter.
- BAUD_VAL=0 is treated as 1.
- After the 11th terminal count (bit counter reaches 11): enter FIN.
- FIN: DONE=1 for exactly one cycle, TX=1, unconditional return to IDLE.
- Config inputs and BAUD_VAL changing mid-frame have no effect until the next load.
- DOIT going low mid-frame does not abort the frame.

## Timing
- Reset values: TX=1, DONE=0, state IDLE, counters 0, shift register all ones.
- Reset mid-frame aborts immediately to these values.
- DOIT sampled at edge E0:
  - TX=0 from E0 through E0+BAUD_VAL.
  - Bit k occupies [E0+k·BAUD_VAL, E0+(k+1)·BAUD_VAL).
- DONE is high during the single cycle after edge E0+11·BAUD_VAL. DONE is registered, with no combinational path from inputs.
- Back-to-back: the handshake stage keeps DOIT high through the DONE cycle when a new write coincides.
  - The engine spends the FIN cycle, then one IDLE cycle sampling DOIT.
  - The next start bit begins 2 clocks after the frame's 11th bit time ends (TX stays 1 in between).
- No restart from FIN: the stale DOIT seen during DONE must not launch a duplicate frame.

## Configuration
- TX_PARITY_EN defined: PEN/OHEL behave as above.
- TX_PARITY_EN undefined:
  - Parity logic is removed and PEN is treated as 0.
  - Frames use the PEN=0 layouts; OHEL is ignored.
  - Frame length stays 11 bit times.

## Structure
- Package tx_pkg:
  - State enum (IDLE, SHIFT, FIN).
  - FRAME_BITS=11.
  - Parity helper function taking data and EIGHT/OHEL.
- Sub-module tx_baud_gen:
  - Divisor counter with clear and enable.
  - Emits a one-cycle terminal-count tick.
  - Instantiated once.

## Test plan
- Reset, then BAUD_VAL=4, EIGHT=1, PEN=1, OHEL=0, LOAD_DATA=8'hA5, DOIT high one edge:
  - TX bit sequence 0,1,0,1,0,0,1,0,1,0,1, each exactly 4 clocks.
  - DONE single pulse in cycle 45 after the sampling edge.
- EIGHT=0, PEN=0, LOAD_DATA=8'hC1, BAUD_VAL=3:
  - TX sequence 0,1,0,0,0,0,0,1,1,1,1.
  - Bit 7 of the data is not transmitted.
- EIGHT=1, PEN=1, OHEL=1, LOAD_DATA=8'h00: parity bit (bit 9) = 1. Repeat with OHEL=0: parity bit = 0.
- DOIT held high through DONE (simulated coincident write, data 8'h3C after 8'hA5):
  - Exactly two frames.
  - Exactly 2 idle-high clocks between the first stop bit time and the second start bit.
  - No third frame after DOIT drops.
- Assert reset low mid-data-bit 4:
  - TX=1 and DONE=0 immediately (asynchronous).
  - After release with DOIT low, TX remains 1 and DONE never pulses.
- Change BAUD_VAL 4→8 and PEN 1→0 during a frame:
  - Current frame completes at 4 clocks/bit with parity.
  - Next frame uses 8 clocks/bit without parity.
